// File: rtl/acia_ctrl.sv
// ACIA bus master: power-up configuration, status polling, round-robin TX
// sharing between two byte requesters, and a one-entry RX output buffer.
module acia_ctrl #(
    parameter logic [7:0] CTRL_INIT = 8'h15
) (
    input  logic       clk,
    input  logic       rst,
    output logic       acia_cs,
    output logic       acia_we,
    output logic       acia_rs,
    output logic [7:0] acia_din,
    input  logic [7:0] acia_dout,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] err_count
);

    localparam logic [2:0] S_INIT_RST = 3'd0;
    localparam logic [2:0] S_INIT_CFG = 3'd1;
    localparam logic [2:0] S_POLL     = 3'd2;
    localparam logic [2:0] S_EVAL     = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_READ     = 3'd5;
    localparam logic [2:0] S_CAPTURE  = 3'd6;

    logic [2:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q;
    logic       err_prev_q;
    logic [7:0] err_cnt_q;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       eval_grant;

    // On a tie the requester that did not win last time is served.
    assign eval_grant = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            S_INIT_RST: state_d = S_INIT_CFG;
            S_INIT_CFG: state_d = S_POLL;
            S_POLL:     state_d = S_EVAL;
            S_EVAL: begin
                if (acia_dout[0] && !rx_valid_q) begin
                    state_d = S_READ;
                end else if (acia_dout[1] && (req0_valid || req1_valid)) begin
                    state_d = S_WRITE;
                    grant_d = eval_grant;
                end else begin
                    state_d = S_POLL;
                end
            end
            S_WRITE:    state_d = S_POLL;
            S_READ:     state_d = S_CAPTURE;
            S_CAPTURE:  state_d = S_POLL;
            default:    state_d = S_INIT_RST;
        endcase
    end

    // Bus strobes are gated by rst so nothing reaches the ACIA while reset is held.
    always_comb begin
        acia_cs    = 1'b0;
        acia_we    = 1'b0;
        acia_rs    = 1'b0;
        acia_din   = 8'h00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                S_INIT_RST: begin
                    acia_cs  = 1'b1;
                    acia_we  = 1'b1;
                    acia_din = 8'h03;
                end
                S_INIT_CFG: begin
                    acia_cs  = 1'b1;
                    acia_we  = 1'b1;
                    acia_din = CTRL_INIT;
                end
                S_POLL: acia_cs = 1'b1;
                S_WRITE: begin
                    acia_cs    = 1'b1;
                    acia_we    = 1'b1;
                    acia_rs    = 1'b1;
                    acia_din   = grant_q ? req1_data : req0_data;
                    req0_ready = ~grant_q;
                    req1_ready = grant_q;
                end
                S_READ: begin
                    acia_cs = 1'b1;
                    acia_rs = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= S_INIT_RST;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_prev_q   <= 1'b0;
            err_cnt_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (state_q == S_WRITE) begin
                last_grant_q <= grant_q;
            end
            if (state_q == S_EVAL) begin
                err_prev_q <= acia_dout[4];
                if (acia_dout[4] && !err_prev_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
            if (state_q == S_CAPTURE) begin
                rx_data_q  <= acia_dout;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_acia_ctrl.sv
// Bench for acia_ctrl: behavioural ACIA, queued requesters, a per-cycle bus
// protocol model and directed scenarios with literal expectations.
module tb_acia_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       acia_cs, acia_we, acia_rs;
    logic [7:0] acia_din;
    logic [7:0] acia_dout = 8'h00;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic [7:0] err_count;

    acia_ctrl #(.CTRL_INIT(8'h15)) dut (
        .clk       (clk),
        .rst       (rst),
        .acia_cs   (acia_cs),
        .acia_we   (acia_we),
        .acia_rs   (acia_rs),
        .acia_din  (acia_din),
        .acia_dout (acia_dout),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural ACIA ----------------
    logic [7:0] rx_bytes [16];
    int         rx_avail = 0;
    int         rx_rd_idx = 0;
    logic       tx_line_en = 1'b0;
    int         tx_time = 20;
    int         tx_busy = 0;
    logic       err_mode = 1'b0;
    logic       err_hold = 1'b0;
    logic       err_last = 1'b0;
    logic       s_cs = 1'b0, s_we = 1'b0, s_rs = 1'b0;
    logic       e_now;
    logic [7:0] status_now;

    always_comb begin
        e_now      = err_mode ? ~err_last : err_hold;
        status_now = {3'b000, e_now, 2'b00, (tx_line_en && (tx_busy == 0)), (rx_rd_idx < rx_avail)};
    end

    always @(negedge clk) begin
        s_cs = acia_cs;
        s_we = acia_we;
        s_rs = acia_rs;
    end

    always @(posedge clk) begin
        if (s_cs && !s_we) begin
            if (s_rs) begin
                acia_dout <= rx_bytes[rx_rd_idx % 16];
                rx_rd_idx <= rx_rd_idx + 1;
            end else begin
                acia_dout <= status_now;
                err_last  <= e_now;
            end
        end
        if (s_cs && s_we && s_rs) tx_busy <= tx_time;
        else if (tx_busy > 0) tx_busy <= tx_busy - 1;
    end

    // ---------------- requesters ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         acks0 = 0, acks1 = 0;
    int         obs_op;
    logic [7:0] obs_din;
    logic       obs_r0, obs_r1;
    logic       chk_on = 1'b0;

    function automatic int op_of(input logic cs, input logic we, input logic rs);
        if (!cs) return 0;
        if (we) return rs ? 3 : 1;
        return rs ? 4 : 2;
    endfunction

    task automatic drive();
        req0_valid = (q0.size() != 0);
        req0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
        req1_valid = (q1.size() != 0);
        req1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    // One clock: observe the bus mid-cycle, then retire accepted bytes after the edge.
    task automatic step();
        @(negedge clk);
        obs_op  = op_of(acia_cs, acia_we, acia_rs);
        obs_din = acia_din;
        obs_r0  = req0_ready;
        obs_r1  = req1_ready;
        @(posedge clk);
        #1;
        if (obs_r0 && q0.size() != 0) begin
            void'(q0.pop_front());
            acks0++;
        end
        if (obs_r1 && q1.size() != 0) begin
            void'(q1.pop_front());
            acks1++;
        end
        drive();
    endtask

    task automatic setup();
        q0.delete();
        q1.delete();
        acks0      = 0;
        acks1      = 0;
        tx_line_en = 1'b0;
        tx_time    = 20;
        err_mode   = 1'b0;
        err_hold   = 1'b0;
        rx_ready   = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // ---------------- per-cycle protocol model ----------------
    // Bus operations: 0 idle, 1 control write, 2 status read, 3 data write, 4 data read.
    task automatic compare_loop();
        int         op, prev_op, exp_op, dec_op, since_rel, rd_cnt, g;
        logic       prev_eval, eval_now, exp_prev_e, exp_last, exp_rxv;
        logic [7:0] exp_err, exp_rxd, cap_byte, st;
        prev_op = 0; exp_op = 0; dec_op = 2; since_rel = 0; rd_cnt = 0;
        prev_eval = 1'b0; exp_prev_e = 1'b0; exp_last = 1'b1; exp_rxv = 1'b0;
        exp_err = 8'h00; exp_rxd = 8'h00; cap_byte = 8'h00;
        forever begin
            @(negedge clk);
            op       = op_of(acia_cs, acia_we, acia_rs);
            eval_now = !rst && (since_rel >= 3) && (prev_op == 2);
            st       = acia_dout;
            g        = (req0_valid && req1_valid) ? (exp_last ? 0 : 1) : (req1_valid ? 1 : 0);
            if (since_rel < 2)      exp_op = 1;
            else if (since_rel == 2) exp_op = 2;
            else if (prev_op == 2)   exp_op = 0;
            else if (prev_eval)      exp_op = dec_op;
            else if (prev_op == 4)   exp_op = 0;
            else                     exp_op = 2;
            if (chk_on) begin
                if (rst) begin
                    check("rst_outputs", {acia_cs, acia_we, acia_rs, acia_din, req0_ready, req1_ready}, 0);
                end else begin
                    check("bus_op", op, exp_op);
                    if (since_rel < 2 && op == 1)
                        check("init_din", acia_din, (since_rel == 0) ? 8'h03 : 8'h15);
                    if (op == 0) check("idle_din", acia_din, 0);
                    if (op == 3) begin
                        check("wr_din", acia_din, (g == 1) ? req1_data : req0_data);
                        check("wr_ready", {req0_ready, req1_ready}, (g == 1) ? 2'b01 : 2'b10);
                    end else begin
                        check("no_ready", {req0_ready, req1_ready}, 0);
                    end
                    check("err_count", err_count, exp_err);
                    check("rx_valid", rx_valid, exp_rxv);
                    check("rx_data", rx_data, exp_rxd);
                end
            end
            if (rst) begin
                exp_err = 8'h00; exp_prev_e = 1'b0; exp_last = 1'b1;
                exp_rxv = 1'b0; exp_rxd = 8'h00; since_rel = 0;
            end else begin
                if (eval_now) begin
                    if (st[0] && !exp_rxv)                        dec_op = 4;
                    else if (st[1] && (req0_valid || req1_valid)) dec_op = 3;
                    else                                          dec_op = 2;
                    if (st[4] && !exp_prev_e && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                    exp_prev_e = st[4];
                end
                if (exp_rxv && rx_ready) exp_rxv = 1'b0;
                if (prev_op == 4) begin
                    exp_rxv = 1'b1;
                    exp_rxd = cap_byte;
                end
                if (op == 4) begin
                    cap_byte = rx_bytes[rd_cnt % 16];
                    rd_cnt++;
                end
                if (op == 3) exp_last = (g == 1);
                if (since_rel < 3) since_rel++;
            end
            prev_eval = eval_now;
            prev_op   = rst ? 0 : op;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] wlog[$];
        int         found, writes, rd_before, rd_c, wr_c;
        fork
            compare_loop();
        join_none
        for (int i = 0; i < 16; i++) rx_bytes[i] = 8'h00;
        setup();
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;

        // Reset values and the init sequence.
        rst = 1'b1;
        repeat (3) step();
        check("rst_bus_idle", obs_op, 0);
        check("rst_ready", {obs_r0, obs_r1}, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_err_count", err_count, 8'h00);
        rst = 1'b0;
        step(); check("init0_op", obs_op, 1); check("init0_din", obs_din, 8'h03);
        step(); check("init1_op", obs_op, 1); check("init1_din", obs_din, 8'h15);
        step(); check("init2_op", obs_op, 2);
        step(); check("init3_op", obs_op, 0);

        // Single TX from requester 0.
        setup();
        q0.push_back(8'h41);
        tx_line_en = 1'b1;
        drive();
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (obs_op == 3) found = 1;
        end
        check("tx_found", found, 1);
        check("tx_din", obs_din, 8'h41);
        check("tx_ready", {obs_r0, obs_r1}, 2'b10);
        tx_line_en = 1'b0;
        writes = 0;
        repeat (20) begin
            step();
            if (obs_op == 3) writes++;
        end
        check("tx_no_rewrite", writes, 0);
        check("tx_acks", acks0, 1);

        // Contention: round-robin order A0, B1, A0, B1.
        setup();
        q0.push_back(8'hA0); q0.push_back(8'hA0);
        q1.push_back(8'hB1); q1.push_back(8'hB1);
        tx_line_en = 1'b1;
        tx_time    = 2;
        drive();
        wlog.delete();
        do_reset();
        repeat (50) begin
            step();
            if (obs_op == 3) wlog.push_back(obs_din);
        end
        check("rr_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("rr_w0", wlog[0], 8'hA0);
            check("rr_w1", wlog[1], 8'hB1);
            check("rr_w2", wlog[2], 8'hA0);
            check("rr_w3", wlog[3], 8'hB1);
        end

        // RX with backpressure.
        setup();
        rx_bytes[rx_avail % 16]       = 8'h5A;
        rx_bytes[(rx_avail + 1) % 16] = 8'hC3;
        rx_avail  = rx_avail + 2;
        rd_before = rx_rd_idx;
        do_reset();
        repeat (30) step();
        check("rx_bp_valid", rx_valid, 1);
        check("rx_bp_data", rx_data, 8'h5A);
        check("rx_bp_reads", rx_rd_idx - rd_before, 1);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        repeat (30) step();
        check("rx_next_valid", rx_valid, 1);
        check("rx_next_data", rx_data, 8'hC3);
        check("rx_next_reads", rx_rd_idx - rd_before, 2);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;

        // RX served before TX when both are pending.
        setup();
        q1.push_back(8'h99);
        tx_line_en = 1'b1;
        rx_bytes[rx_avail % 16] = 8'h77;
        rx_avail = rx_avail + 1;
        drive();
        do_reset();
        rd_c = -1;
        wr_c = -1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (obs_op == 4 && rd_c < 0) rd_c = c;
            if (obs_op == 3 && wr_c < 0) wr_c = c;
        end
        check("prio_read_cycle", rd_c, 4);
        check("prio_write_cycle", wr_c, 8);
        check("prio_rx_data", rx_data, 8'h77);
        check("prio_acks1", acks1, 1);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;

        // Error counter saturation, then level-held error counts once.
        setup();
        err_mode = 1'b1;
        do_reset();
        repeat (1300) step();
        check("err_saturate", err_count, 8'hFF);
        err_mode = 1'b0;
        err_hold = 1'b1;
        do_reset();
        repeat (20) step();
        check("err_hold_once", err_count, 8'h01);
        err_hold = 1'b0;
        repeat (10) step();
        err_hold = 1'b1;
        repeat (10) step();
        check("err_second_edge", err_count, 8'h02);
        err_hold = 1'b0;

        // Reset asserted during WRITE.
        setup();
        q0.push_back(8'h5C);
        tx_line_en = 1'b1;
        drive();
        do_reset();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (acia_cs && acia_we && acia_rs) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("rstw_found", found, 1);
        rst = 1'b1;
        step();
        check("rstw_no_ready", {obs_r0, obs_r1}, 0);
        check("rstw_no_op", obs_op, 0);
        rst = 1'b0;
        step(); check("rstw_init0", {obs_op[7:0], obs_din}, {8'd1, 8'h03});
        step(); check("rstw_init1", {obs_op[7:0], obs_din}, {8'd1, 8'h15});
        step(); check("rstw_init2", obs_op, 2);
        repeat (20) step();
        check("rstw_acks", acks0, 1);
        check("rstw_drained", q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
